// File: rtl/implication_responder.sv
// implication_responder: answers each accepted antecedent with one consequent pulse
// LATENCY cycles later, tracking in-flight requests and flagging drops at capacity.
`default_nettype none

module implication_responder #(
  parameter int LATENCY         = 1,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CW              = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          antecedent,
  input  logic          clear_overflow,
  output logic          consequent,
  output logic [CW-1:0] outstanding,
  output logic          busy,
  output logic          overflow
);

  logic accept;
  logic drop;

  generate
    if (LATENCY == 0) begin : g_comb
      // Overlapping form: the response is the accept itself, masked while in reset.
      assign accept      = enable && antecedent;
      assign consequent  = rst_n && accept;
      assign outstanding = '0;
      assign busy        = 1'b0;
    end else begin : g_pipe
      logic [LATENCY-1:0] line;
      logic [CW-1:0]      count;
      logic [CW-1:0]      count_next;
      logic               retire;
      logic               has_room;

      assign retire   = line[LATENCY-1];
      // A retiring response frees its slot in the same cycle.
      assign has_room = (count < CW'(MAX_OUTSTANDING)) || retire;
      assign accept   = enable && antecedent && has_room;

      always_comb begin
        count_next = count;
        if (accept && !retire) begin
          count_next = count + CW'(1);
        end else if (!accept && retire) begin
          count_next = count - CW'(1);
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          line  <= '0;
          count <= '0;
          busy  <= 1'b0;
        end else begin
          line  <= (line << 1) | LATENCY'(accept);
          count <= count_next;
          busy  <= (count_next != '0);
        end
      end

      assign consequent  = retire;
      assign outstanding = count;
    end
  endgenerate

  assign drop = enable && antecedent && !accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clear_overflow) begin
      overflow <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_implication_responder.sv
// Bench for implication_responder: five configurations share one stimulus stream and
// are checked every cycle against a due-time model plus literal expectations.
`default_nettype none

module tb_implication_responder;

  localparam int N = 5;
  localparam int LAT_T [N] = '{1, 0, 4, 3, 2};
  localparam int MAX_T [N] = '{4, 4, 2, 4, 4};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b1;
  logic antecedent = 1'b0;
  logic clear_overflow = 1'b0;

  logic       cons_a [N];
  logic       busy_a [N];
  logic       ovf_a  [N];
  logic [3:0] out_a  [N];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  generate
    for (genvar g = 0; g < N; g++) begin : g_dut
      localparam int W = $clog2(MAX_T[g] + 1);
      logic [W-1:0] o_w;
      logic c_w, b_w, v_w;
      implication_responder #(
        .LATENCY(LAT_T[g]),
        .MAX_OUTSTANDING(MAX_T[g])
      ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .antecedent(antecedent),
        .clear_overflow(clear_overflow),
        .consequent(c_w),
        .outstanding(o_w),
        .busy(b_w),
        .overflow(v_w)
      );
      assign cons_a[g] = c_w;
      assign busy_a[g] = b_w;
      assign ovf_a[g]  = v_w;
      assign out_a[g]  = 4'(o_w);
    end
  endgenerate

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: each accepted request is a due-cycle mark; outstanding is the count of marks.
  bit due_m [N][64];
  int pend  [N];
  bit ovf_m [N];
  int mcyc = 0;

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      bit ec, eov, ret, req, room, acc;
      int eo;
      ret = 0;
      acc = 0;
      req = enable && antecedent;
      if (!rst_n) begin
        for (int d = 0; d < 64; d++) due_m[i][d] = 0;
        pend[i]  = 0;
        ovf_m[i] = 0;
        ec = 0; eo = 0; eov = 0;
      end else if (LAT_T[i] == 0) begin
        ec = req; eo = 0; eov = ovf_m[i];
      end else begin
        ret = due_m[i][mcyc % 64];
        ec  = ret; eo = pend[i]; eov = ovf_m[i];
      end
      chk($sformatf("consequent[%0d]", i), int'(cons_a[i]), int'(ec));
      chk($sformatf("outstanding[%0d]", i), int'(out_a[i]), eo);
      chk($sformatf("busy[%0d]", i), int'(busy_a[i]), int'(eo != 0));
      chk($sformatf("overflow[%0d]", i), int'(ovf_a[i]), int'(eov));
      if (rst_n && LAT_T[i] != 0) begin
        room = (pend[i] < MAX_T[i]) || ret;
        acc  = req && room;
        if (ret) begin
          due_m[i][mcyc % 64] = 0;
          pend[i]--;
        end
        if (acc) begin
          due_m[i][(mcyc + LAT_T[i]) % 64] = 1;
          pend[i]++;
        end
        if (req && !room) ovf_m[i] = 1;
        else if (clear_overflow) ovf_m[i] = 0;
      end
    end
    mcyc++;
  end

  task automatic hold_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; antecedent = 1'b0; enable = 1'b1; clear_overflow = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic drive(input bit rst, input bit ant, input bit en, input bit clr);
    @(posedge clk); #1;
    rst_n = rst; antecedent = ant; enable = en; clear_overflow = clr;
  endtask

  task automatic mid();
    @(negedge clk); #1;
  endtask

  initial begin
    // Single pulse at cycle 5, LATENCY=1 (also covers the first post-reset cycle).
    hold_reset();
    for (int c = 0; c < 10; c++) begin
      drive(1, c == 5, 1, 0);
      mid();
      if (c == 0) chk("L1 first cycle consequent", int'(cons_a[0]), 0);
      if (c == 5) chk("L1 consequent c5", int'(cons_a[0]), 0);
      if (c == 6) chk("L1 consequent c6", int'(cons_a[0]), 1);
      if (c == 6) chk("L1 outstanding c6", int'(out_a[0]), 1);
      if (c == 7) chk("L1 consequent c7", int'(cons_a[0]), 0);
      if (c == 7) chk("L1 outstanding c7", int'(out_a[0]), 0);
      if (c == 9) chk("L1 overflow", int'(ovf_a[0]), 0);
    end

    // LATENCY=0, antecedent in cycles 3-4.
    hold_reset();
    for (int c = 0; c < 8; c++) begin
      drive(1, c == 3 || c == 4, 1, 0);
      mid();
      if (c >= 2 && c <= 5) chk($sformatf("L0 consequent c%0d", c), int'(cons_a[1]), int'(c == 3 || c == 4));
      if (c == 4) chk("L0 outstanding", int'(out_a[1]), 0);
    end

    // LATENCY=4, MAX=2: third request dropped, clear at cycle 10.
    hold_reset();
    for (int c = 0; c < 13; c++) begin
      drive(1, c <= 2, 1, c == 10);
      mid();
      if (c == 4) chk("L4 consequent c4", int'(cons_a[2]), 1);
      if (c == 5) chk("L4 consequent c5", int'(cons_a[2]), 1);
      if (c == 6) chk("L4 consequent c6", int'(cons_a[2]), 0);
      if (c == 2) chk("L4 overflow c2", int'(ovf_a[2]), 0);
      if (c == 3) chk("L4 overflow c3", int'(ovf_a[2]), 1);
      if (c == 10) chk("L4 overflow c10", int'(ovf_a[2]), 1);
      if (c == 11) chk("L4 overflow c11", int'(ovf_a[2]), 0);
    end

    // LATENCY=3, accept at cycle 2, then enable low with antecedent held.
    hold_reset();
    for (int c = 0; c < 10; c++) begin
      drive(1, c >= 2, c <= 2, 0);
      mid();
      if (c == 5) chk("L3 consequent c5", int'(cons_a[3]), 1);
      if (c == 8) chk("L3 consequent c8", int'(cons_a[3]), 0);
      if (c == 5) chk("L3 busy c5", int'(busy_a[3]), 1);
      if (c == 6) chk("L3 busy c6", int'(busy_a[3]), 0);
      if (c == 9) chk("L3 overflow", int'(ovf_a[3]), 0);
    end

    // LATENCY=2, reset asserted mid-cycle 1, released at cycle 3.
    hold_reset();
    for (int c = 0; c < 8; c++) begin
      drive(c >= 3 || c == 0 || c == 1, c <= 1, 1, 0);
      if (c == 1) begin
        #1 chk("L2 outstanding before reset", int'(out_a[4]), 1);
        #1 rst_n = 1'b0;
        #1 chk("L2 outstanding in reset", int'(out_a[4]), 0);
      end
      mid();
      if (c >= 2 && c <= 6) chk($sformatf("L2 consequent c%0d", c), int'(cons_a[4]), 0);
    end

    // Held antecedent at capacity: retire frees a slot; set beats clear.
    hold_reset();
    for (int c = 0; c < 12; c++) begin
      drive(1, c <= 5, 1, c == 2);
      mid();
      if (c == 3) chk("L4 set-wins overflow", int'(ovf_a[2]), 1);
      if (c == 6) chk("L4 consequent c6 held", int'(cons_a[2]), 0);
      if (c == 8) chk("L4 consequent c8 held", int'(cons_a[2]), 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
